mil1553_tx_sched: RTL and testbench
===================================

# mil1553_tx_sched

Message-level scheduler that shares the single MIL-STD-1553 transmit encoder of the UART/1553 core between two word sources: host-decoded words from the UART receive path (requester 0) and locally generated status/loopback words (requester 1). Each requester offers whole messages, one 16-bit word at a time. The block grants the encoder to one requester per message, using round-robin order. It keeps a granted message contiguous, limits message length, aborts stalled senders and enforces the minimum inter-message bus gap.

## Interface
Parameters:
- msg_gap_cycles, 200 — minimum idle cycles with the encoder input empty between messages (4 µs at 50 MHz); legal range ≥1.
- stall_cycles, 50 — cycles the granted requester may withhold s_valid mid-message before an abort; ≥1.
- max_words, 33 — word limit per message (command word plus 32 data words).

Ports:
- aclk  in  1  sole clock.
- arstn  in  1  reset, synchronous, active-low, sampled on rising aclk.
- s_dat  in  2x16  per-requester word.
- s_cmd  in  2  per-requester sync select: 1 = command/status sync, 0 = data sync.
- s_last  in  2  per-requester end-of-message flag.
- s_valid  in  2  per-requester word valid.
- s_ready  out  2  per-requester word accept.
- m_dat  out  16  word to encoder.
- m_cmd  out  1  sync select to encoder.
- m_last  out  1  final word of message.
- m_valid  out  1  word valid to encoder.
- m_ready  in  1  encoder accepts word.
- grant  out  2  one-hot current owner; 0 in IDLE/GAP.
- busy  out  1  state ≠ IDLE.
- err_stall  out  1  one-cycle pulse on stall abort.
- err_len  out  1  one-cycle pulse on forced length termination.

## Operation
- States:
  - IDLE: if any s_valid is high, register grant and go to XFER next cycle.
  - XFER: stream words from the granted requester.
  - GAP: hold off all requesters; go to IDLE when the gap counter reaches msg_gap_cycles.
- Round-robin arbitration:
  - With one requester valid, that requester wins.
  - With both valid, the requester not served last wins.
  - Reset sets last-served = 1, so requester 0 wins the first tie.
- Output register: single stage holding m_dat, m_cmd, m_last, m_valid. Loads when m_valid=0 or m_ready=1. Contents never change while m_valid=1 and m_ready=0.
- XFER:
  - s_ready[g] = ~m_valid | m_ready. s_ready of the non-granted requester is 0.
  - Each s_valid&s_ready handshake loads the word into the output register and increments the word counter.
  - Word loaded with s_last=1: go to GAP.
  - Word counter reaches max_words without s_last: load that word with m_last forced to 1, pulse err_len, go to GAP. The requester's remaining words form a new message.
  - Stall counter increments on each XFER cycle with s_valid[g]=0 once at least one word has been taken, and clears on every handshake. When it reaches stall_cycles: pulse err_stall, go to GAP. A word already held in the output register is still delivered unchanged.
- GAP: the counter increments only on cycles with m_valid=0, so the gap is measured from the last word leaving the register. s_ready = 0 throughout.
- Reset (arstn=0 at any time, including mid-message):
  - State goes to IDLE; all counters clear.
  - All outputs are 0: m_valid, m_dat, m_cmd, m_last, s_ready, grant, busy, err_*.
  - In-flight words are dropped.
- Simultaneous events:
  - Stall threshold and a handshake in the same cycle: the handshake wins and the counter clears.
  - s_last on the max_words-th word: normal end, no err_len.

## Timing
- IDLE→XFER: one cycle after s_valid is seen. First s_ready is high in the first XFER cycle; m_valid is high on the following cycle.
- Throughput: one word per cycle while m_ready=1.
- Latency: s_valid&s_ready → m_valid is 1 cycle.
- Error pulses are asserted in the cycle after the triggering condition, for exactly one cycle.
- Minimum time from the last m_valid&m_ready of one message to the next grant: msg_gap_cycles + 1 cycles.

## Structure
- Shared package mil1553_sched_pkg contains:
  - State enum: IDLE, XFER, GAP.
  - Word-field widths: 16-bit data, sync select.
  - Default MAX_WORDS = 33.
- Sub-module mil1553_rr_arb: 2-way round-robin arbiter with a last-served register and a load-grant strobe from the FSM.
- Counters (gap, stall, word) stay in the top level.

## Test plan
- Reset mid-message: arstn=0 on word 3 of a 5-word req0 message → next cycle all outputs 0, state IDLE; after release, a fresh req0 message is granted from word 0.
- Both requesters valid at reset release, each with a 2-word message:
  - Order on m_*: req0 words, then req1 words.
  - Measured gap between the messages is 200 + 1 cycles.
- m_ready held low for 10 cycles mid-message → m_dat stable and s_ready=0 throughout; no stall error is raised, because s_valid is held.
- req1 drops s_valid after word 2 for 50 cycles → err_stall pulses once, the held word is delivered, and GAP is entered. req1 reasserting s_valid during GAP sees s_ready=0.
- 40-word message from req0 without s_last:
  - Word 33 is delivered with m_last=1 and err_len pulses once.
  - After the gap, words 34–40 go out as a new message.
- Word 33 with s_last=1 → normal end, err_len stays 0.

Source files
------------

// File: rtl/mil1553_sched_pkg.sv
// Shared types for the 1553 transmit scheduler: FSM states, word fields,
// requester count and default message length limit.
package mil1553_sched_pkg;
  localparam int NUM_REQ   = 2;
  localparam int DAT_W     = 16;
  localparam int SYNC_W    = 1;
  localparam int MAX_WORDS = 33;

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_e;

  typedef struct packed {
    logic [DAT_W-1:0]  dat;
    logic [SYNC_W-1:0] cmd;
    logic              last;
  } word_t;
endpackage

// File: rtl/mil1553_rr_arb.sv
// Two-way round-robin arbiter. Grant is registered on ld and held until clr;
// last_srv remembers the previous owner to break ties.
module mil1553_rr_arb
  import mil1553_sched_pkg::*;
(
  input  logic               aclk,
  input  logic               arstn,
  input  logic [NUM_REQ-1:0] req,
  input  logic               ld,
  input  logic               clr,
  output logic [NUM_REQ-1:0] grant
);
  logic               last_srv;
  logic [NUM_REQ-1:0] win;

  // On a tie the requester not served last wins
  always_comb begin
    win = '0;
    if (req[0] && (!req[1] || last_srv)) win = 2'b01;
    else if (req[1])                     win = 2'b10;
  end

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      grant    <= '0;
      last_srv <= 1'b1;
    end else if (ld && |req) begin
      grant    <= win;
      last_srv <= win[1];
    end else if (clr) begin
      grant    <= '0;
    end
  end
endmodule

// File: rtl/mil1553_tx_sched.sv
// Message-level scheduler sharing the 1553 transmit encoder between two
// word sources, with length limit, stall abort and inter-message gap.
module mil1553_tx_sched
  import mil1553_sched_pkg::*;
#(
  parameter int msg_gap_cycles = 200,
  parameter int stall_cycles   = 50,
  parameter int max_words      = MAX_WORDS
) (
  input  logic                          aclk,
  input  logic                          arstn,
  input  logic [NUM_REQ-1:0][DAT_W-1:0] s_dat,
  input  logic [NUM_REQ-1:0]            s_cmd,
  input  logic [NUM_REQ-1:0]            s_last,
  input  logic [NUM_REQ-1:0]            s_valid,
  output logic [NUM_REQ-1:0]            s_ready,
  output logic [DAT_W-1:0]              m_dat,
  output logic                          m_cmd,
  output logic                          m_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          err_stall,
  output logic                          err_len
);
  localparam int WC_W = $clog2(max_words + 1);
  localparam int SC_W = $clog2(stall_cycles + 1);
  localparam int GC_W = $clog2(msg_gap_cycles + 1);

  state_e             state;
  logic [WC_W-1:0]    wcnt;
  logic [SC_W-1:0]    scnt;
  logic [GC_W-1:0]    gcnt;
  logic [NUM_REQ-1:0] hs_vec;
  logic               ld_ok, hs, len_hit, stall_hit, gap_hit, xfer_end;
  word_t              sel;
  logic               sel_valid;

  assign ld_ok = ~m_valid | m_ready;

  genvar i;
  for (i = 0; i < NUM_REQ; i++) begin : g_req
    assign s_ready[i] = (state == XFER) & grant[i] & ld_ok;
    assign hs_vec[i]  = s_valid[i] & s_ready[i];
  end

  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (grant[r]) begin
        sel       = '{dat: s_dat[r], cmd: s_cmd[r], last: s_last[r]};
        sel_valid = s_valid[r];
      end
    end
  end

  assign hs        = |hs_vec;
  // wcnt counts words already taken, so this handshake is the max_words-th
  assign len_hit   = (wcnt == WC_W'(max_words - 1));
  assign stall_hit = !sel_valid && (wcnt != '0) && (scnt == SC_W'(stall_cycles - 1));
  assign gap_hit   = !m_valid && (gcnt == GC_W'(msg_gap_cycles - 1));
  assign xfer_end  = hs ? (sel.last | len_hit) : stall_hit;
  assign busy      = (state != IDLE);

  mil1553_rr_arb u_arb (
    .aclk  (aclk),
    .arstn (arstn),
    .req   (s_valid),
    .ld    (state == IDLE),
    .clr   ((state == XFER) && xfer_end),
    .grant (grant)
  );

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      state     <= IDLE;
      wcnt      <= '0;
      scnt      <= '0;
      gcnt      <= '0;
      m_dat     <= '0;
      m_cmd     <= 1'b0;
      m_last    <= 1'b0;
      m_valid   <= 1'b0;
      err_stall <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      err_stall <= 1'b0;
      err_len   <= 1'b0;

      if (hs) begin
        m_dat   <= sel.dat;
        m_cmd   <= sel.cmd;
        m_last  <= sel.last | len_hit;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          wcnt <= '0;
          scnt <= '0;
          gcnt <= '0;
          if (|s_valid) state <= XFER;
        end
        XFER: begin
          if (hs) begin
            wcnt <= wcnt + WC_W'(1);
            scnt <= '0;
          end else if (!sel_valid && (wcnt != '0)) begin
            scnt <= scnt + SC_W'(1);
          end
          if (xfer_end) begin
            state     <= GAP;
            gcnt      <= '0;
            err_len   <= hs & len_hit & ~sel.last;
            err_stall <= ~hs;
          end
        end
        GAP: begin
          // Gap is timed from the last word leaving the output register
          if (!m_valid) begin
            gcnt <= gcnt + GC_W'(1);
            if (gap_hit) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mil1553_tx_sched.sv
// Directed bench for mil1553_tx_sched: two scripted word sources, an output
// monitor and hand-computed expectations for each scenario.
module tb_mil1553_tx_sched;
  import mil1553_sched_pkg::*;

  logic tb_data_clk = 1'b0;
  always #5 tb_data_clk = ~tb_data_clk;

  logic             arstn;
  logic [1:0][15:0] s_dat;
  logic [1:0]       s_cmd, s_last, s_valid, s_ready;
  logic [15:0]      m_dat;
  logic             m_cmd, m_last, m_valid, m_ready;
  logic [1:0]       grant;
  logic             busy, err_stall, err_len;

  mil1553_tx_sched dut (
    .aclk(tb_data_clk), .arstn(arstn),
    .s_dat(s_dat), .s_cmd(s_cmd), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
    .m_dat(m_dat), .m_cmd(m_cmd), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .grant(grant), .busy(busy), .err_stall(err_stall), .err_len(err_len)
  );

  int          n_cmp = 0, n_bad = 0;
  int          len [2], ptr [2];
  bit          en [2], hold [2];
  logic [15:0] base [2];
  logic [16:0] out_q [$];  // {last, dat}
  int          n_stall, n_len, gap_run, gap_res;
  bit          gap_on;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int r = 0; r < 2; r++) begin
      s_valid[r] = en[r] && !hold[r] && (ptr[r] < len[r]);
      s_dat[r]   = base[r] + 16'(ptr[r]);
      s_cmd[r]   = (ptr[r] == 0);
      s_last[r]  = (ptr[r] == len[r] - 1);
    end
  endtask

  // One clock: sample at negedge, advance sources #1 after posedge
  task automatic step();
    bit hs [2];
    @(negedge tb_data_clk);
    for (int r = 0; r < 2; r++) hs[r] = arstn && s_valid[r] && s_ready[r];
    if (arstn && m_valid && m_ready) out_q.push_back({m_last, m_dat});
    if (err_stall) n_stall++;
    if (err_len)   n_len++;
    if (arstn && m_valid && m_ready && m_last) begin
      gap_on = 1; gap_run = 0;
    end else if (gap_on) begin
      if (grant != 2'b00) begin gap_on = 0; gap_res = gap_run; end
      else if (!m_valid)  gap_run++;
    end
    @(posedge tb_data_clk); #1;
    for (int r = 0; r < 2; r++) if (hs[r]) ptr[r]++;
    drive();
  endtask

  task automatic run_words(input int n, input int maxc, input string tag);
    int c = 0;
    while (out_q.size() < n && c < maxc) begin step(); c++; end
    chk(tag, out_q.size(), n);
  endtask

  task automatic wait_idle(input int maxc);
    int c = 0;
    en[0] = 0; en[1] = 0; drive();
    while ((busy || m_valid) && c < maxc) begin step(); c++; end
    chk("idle", {busy, m_valid}, 2'b00);
  endtask

  task automatic start(input int r, input int n);
    ptr[r] = 0; len[r] = n; en[r] = 1; hold[r] = 0;
    drive();
  endtask

  task automatic clear();
    out_q.delete(); n_stall = 0; n_len = 0; gap_res = -1; gap_on = 0;
  endtask

  initial begin
    int c;
    base[0] = 16'hA000; base[1] = 16'hB000;
    for (int r = 0; r < 2; r++) begin len[r] = 0; ptr[r] = 0; en[r] = 0; hold[r] = 0; end
    m_ready = 1; arstn = 0; clear(); drive();
    repeat (3) step();

    // reset state
    chk("rst_mvalid", m_valid, 0);
    chk("rst_mdat", m_dat, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sready", s_ready, 0);

    // tie at reset release: req0 first, then req1 after the gap
    start(0, 2); start(1, 2);
    arstn = 1;
    run_words(4, 600, "tie_cnt");
    chk("tie_w0", out_q[0], 17'h0A000);
    chk("tie_w1", out_q[1], 17'h1A001);
    chk("tie_w2", out_q[2], 17'h0B000);
    chk("tie_w3", out_q[3], 17'h1B001);
    chk("tie_gap", gap_res, 201);
    wait_idle(400);

    // encoder back-pressure mid-message
    clear(); start(0, 5);
    run_words(2, 50, "bp_pre");
    m_ready = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("bp_dat", m_dat, 16'hA002);
      chk("bp_rdy", s_ready, 0);
    end
    m_ready = 1;
    run_words(5, 50, "bp_cnt");
    chk("bp_w2", out_q[2], 17'h0A002);
    chk("bp_w4", out_q[4], 17'h1A004);
    chk("bp_nstall", n_stall, 0);
    wait_idle(400);

    // stall abort with a word held in the output register
    clear(); start(1, 5);
    c = 0;
    while (ptr[1] != 2 && c < 20) begin step(); c++; end
    chk("st_ptr", ptr[1], 2);
    hold[1] = 1; m_ready = 0; drive();
    repeat (49) step();
    chk("st_pre", err_stall, 0);
    chk("st_grant", grant, 2'b10);
    step();
    chk("st_pulse", err_stall, 1);
    chk("st_hold", {m_valid, m_dat}, 17'h1B001);
    hold[1] = 0; drive();
    step();
    chk("st_once", err_stall, 0);
    chk("st_gap_rdy", s_ready, 0);
    m_ready = 1;
    run_words(2, 10, "st_cnt");
    chk("st_word", out_q[1], 17'h0B001);
    run_words(5, 400, "st_rest");
    chk("st_w2", out_q[2], 17'h0B002);
    chk("st_w4", out_q[4], 17'h1B004);
    chk("st_n", n_stall, 1);
    wait_idle(400);

    // 40 words: forced end at word 33, remainder is a new message
    clear(); start(0, 40);
    run_words(40, 800, "len_cnt");
    chk("len_w31", out_q[31], 17'h0A01F);
    chk("len_w32", out_q[32], 17'h1A020);
    chk("len_w33", out_q[33], 17'h0A021);
    chk("len_w39", out_q[39], 17'h1A027);
    chk("len_n", n_len, 1);
    chk("len_gap", gap_res, 201);
    wait_idle(400);

    // s_last on word 33 is a normal end
    clear(); start(0, 33);
    run_words(33, 100, "w33_cnt");
    repeat (2) step();
    chk("w33_last", out_q[32], 17'h1A020);
    chk("w33_nlen", n_len, 0);
    wait_idle(400);

    // reset on word 3 of a 5-word message
    clear(); start(0, 5);
    c = 0;
    while (ptr[0] != 3 && c < 20) begin step(); c++; end
    chk("mr_ptr", ptr[0], 3);
    arstn = 0;
    step();
    chk("mr_mvalid", m_valid, 0);
    chk("mr_mfields", {m_dat, m_cmd, m_last}, 0);
    chk("mr_grant", grant, 0);
    chk("mr_busy", busy, 0);
    chk("mr_sready", s_ready, 0);
    chk("mr_err", {err_stall, err_len}, 0);
    arstn = 1; out_q.delete(); ptr[0] = 0; drive();
    run_words(5, 50, "mr_cnt");
    chk("mr_w0", out_q[0], 17'h0A000);
    chk("mr_w4", out_q[4], 17'h1A004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
